// File: rtl/key_edge_irq_pio_if.sv
// Avalon-MM slave bus bundle for key_edge_irq_pio: word address, strobes, 32-bit data.
interface key_edge_irq_pio_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/key_edge_irq_pio.sv
// Key/switch input PIO: 2-FF sync, optional debounce (KEY_EDGE_IRQ_DEBOUNCE_EN),
// per-bit edge capture with W1C clear, masked level irq, Avalon-MM register access.
module key_edge_irq_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  key_edge_irq_pio_if.slave bus,
  output logic              irq,
  input  logic [WIDTH-1:0]  pio_in
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_MASK    = 2'd1,
    ADDR_CAP     = 2'd2,
    ADDR_EDGESEL = 2'd3
  } reg_addr_e;

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("key_edge_irq_pio: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 2");
  end

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgesel_q, edgesel_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [WIDTH-1:0] rise, fall, edge_det, clr, wr_bits;
  reg_addr_e        addr;
  logic             unused_wdata;

  assign addr         = reg_addr_e'(bus.address);
  assign wr_bits      = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  assign sync1_d = pio_in;
  assign sync2_d = sync1_q;
  assign prev_d  = stable_q;

`ifdef KEY_EDGE_IRQ_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Counter only runs while sync disagrees with the accepted level; any agreement restarts it.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  assign stable_d = sync2_q;
`endif

  always_comb begin
    rise     = stable_q & ~prev_q;
    fall     = ~stable_q & prev_q;
    edge_det = (fall & edgesel_q) | (rise & ~edgesel_q);

    mask_d    = mask_q;
    edgesel_d = edgesel_q;
    clr       = '0;
    if (bus.write) begin
      case (addr)
        ADDR_MASK:    mask_d    = wr_bits;
        ADDR_CAP:     clr       = wr_bits;
        ADDR_EDGESEL: edgesel_d = wr_bits;
        default:      ;
      endcase
    end

    // A new edge in the same cycle as its W1C keeps the bit set.
    cap_d = (cap_q & ~clr) | edge_det;
    irq_d = |(cap_q & mask_q);

    rdata_d = rdata_q;
    if (bus.read) begin
      case (addr)
        ADDR_DATA:    rdata_d = 32'(stable_q);
        ADDR_MASK:    rdata_d = 32'(mask_q);
        ADDR_CAP:     rdata_d = 32'(cap_q);
        ADDR_EDGESEL: rdata_d = 32'(edgesel_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      mask_q    <= '0;
      edgesel_q <= '0;
      cap_q     <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      mask_q    <= mask_d;
      edgesel_q <= edgesel_d;
      cap_q     <= cap_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign irq          = irq_q;
  assign bus.readdata = rdata_q;

endmodule
